lpffir_pipe_axis: RTL and testbench

- Parametrised, pipelined linear-phase (symmetric) FIR filter with AXI-Stream RX/TX.
- Successor of the fixed 6-tap unity-coefficient filter:
  - generic width and tap count
  - run-time programmable coefficients
  - registered 2-stage datapath
  - true backpressure handling
  - tlast-aligned output
  - per-packet delay-line clear
- Sits between the stream source and sink in the DSP chain.

---
 rtl/lpffir_pipe_axis.sv | 129 ++++++++++++
 tb/tb_lpffir_pipe_axis.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/lpffir_pipe_axis.sv
// Symmetric-tap FIR with programmable pair coefficients, 2-stage pipeline and AXI-Stream flow control.
// Optional output saturation and clip flag (sat_o) when LPFFIR_SAT_EN is defined.
module lpffir_pipe_axis #(
    parameter int DATA_W = 16,
    parameter int NTAPS  = 6,
    parameter int COEF_W = 16,
    parameter int SHIFT  = 0,
    localparam int NP    = NTAPS / 2,
    localparam int AW    = (NP > 1) ? $clog2(NP) : 1
) (
    input  logic              aclk_i,
    input  logic              areset_i,
    input  logic              rx_tvalid_i,
    output logic              rx_tready_o,
    input  logic [DATA_W-1:0] rx_tdata_i,
    input  logic              rx_tlast_i,
    output logic              tx_tvalid_o,
    input  logic              tx_tready_i,
    output logic [DATA_W-1:0] tx_tdata_o,
    output logic              tx_tlast_o,
`ifdef LPFFIR_SAT_EN
    output logic              sat_o,
`endif
    input  logic              coef_we_i,
    input  logic [AW-1:0]     coef_addr_i,
    input  logic [COEF_W-1:0] coef_data_i
);
    localparam int ACC_W = DATA_W + 1 + COEF_W + $clog2(NP) + 1;

    logic [DATA_W-1:0]        xr [1:NTAPS-1];
    logic [DATA_W-1:0]        xs [0:NTAPS-1];
    logic signed [DATA_W:0]   p [0:NP-1];
    logic signed [COEF_W-1:0] coef [0:NP-1];
    logic                     t1;
    logic [2:1]               vld_pipe;
    logic                     s1_rdy, s2_rdy, accept;
    logic signed [ACC_W-1:0]  acc;
    logic [DATA_W-1:0]        dout;

    assign s2_rdy      = !vld_pipe[2] | tx_tready_i;
    assign s1_rdy      = !vld_pipe[1] | s2_rdy;
    assign rx_tready_o = s1_rdy;
    assign accept      = rx_tvalid_i & s1_rdy;
    assign tx_tvalid_o = vld_pipe[2];

    // Tap 0 is the incoming sample itself, so the pre-adders see the full window.
    always_comb begin
        xs[0] = rx_tdata_i;
        for (int j = 1; j < NTAPS; j++) xs[j] = xr[j];
    end

    // A tlast beat wipes history so the next packet starts from zeros.
    always_ff @(posedge aclk_i or posedge areset_i) begin
        if (areset_i) begin
            for (int j = 1; j < NTAPS; j++) xr[j] <= '0;
        end else if (accept) begin
            if (rx_tlast_i) begin
                for (int j = 1; j < NTAPS; j++) xr[j] <= '0;
            end else begin
                xr[1] <= rx_tdata_i;
                for (int j = 2; j < NTAPS; j++) xr[j] <= xr[j-1];
            end
        end
    end

    always_ff @(posedge aclk_i or posedge areset_i) begin
        if (areset_i) begin
            vld_pipe[1] <= 1'b0;
            t1          <= 1'b0;
            for (int k = 0; k < NP; k++) p[k] <= '0;
        end else if (s1_rdy) begin
            vld_pipe[1] <= accept;
            if (accept) begin
                t1 <= rx_tlast_i;
                for (int k = 0; k < NP; k++)
                    p[k] <= {xs[k][DATA_W-1], xs[k]} + {xs[NTAPS-1-k][DATA_W-1], xs[NTAPS-1-k]};
            end
        end
    end

    always_ff @(posedge aclk_i or posedge areset_i) begin
        if (areset_i) begin
            for (int k = 0; k < NP; k++) coef[k] <= COEF_W'(1);
        end else if (coef_we_i && int'(coef_addr_i) < NP) begin
            coef[coef_addr_i] <= coef_data_i;
        end
    end

    always_comb begin
        acc = '0;
        for (int k = 0; k < NP; k++) acc = acc + ACC_W'(p[k]) * ACC_W'(coef[k]);
    end

`ifdef LPFFIR_SAT_EN
    logic signed [ACC_W-1:0] shifted;
    logic [ACC_W-DATA_W:0]   hi;
    logic                    clip;
    always_comb begin
        shifted = acc >>> SHIFT;
        hi      = shifted[ACC_W-1:DATA_W-1];
        // In range only when every bit above the output sign bit matches it.
        clip    = !((&hi) | ~(|hi));
        dout    = clip ? {shifted[ACC_W-1], {(DATA_W-1){~shifted[ACC_W-1]}}}
                       : shifted[DATA_W-1:0];
    end
`else
    assign dout = DATA_W'(acc >>> SHIFT);
`endif

    always_ff @(posedge aclk_i or posedge areset_i) begin
        if (areset_i) begin
            vld_pipe[2] <= 1'b0;
            tx_tdata_o  <= '0;
            tx_tlast_o  <= 1'b0;
`ifdef LPFFIR_SAT_EN
            sat_o       <= 1'b0;
`endif
        end else if (s2_rdy) begin
            vld_pipe[2] <= vld_pipe[1];
            if (vld_pipe[1]) begin
                tx_tdata_o <= dout;
                tx_tlast_o <= t1;
`ifdef LPFFIR_SAT_EN
                sat_o      <= clip;
`endif
            end
        end
    end
endmodule

// File: tb/tb_lpffir_pipe_axis.sv
// Scoreboard bench for lpffir_pipe_axis (defaults: 16-bit, 6 taps, SHIFT 0).
module tb_lpffir_pipe_axis;
    logic        aclk = 1'b0;
    logic        areset;
    logic        rx_tvalid, rx_tready, rx_tlast;
    logic [15:0] rx_tdata;
    logic        tx_tvalid, tx_tready, tx_tlast;
    logic [15:0] tx_tdata;
    logic        coef_we;
    logic [1:0]  coef_addr;
    logic [15:0] coef_data;
`ifdef LPFFIR_SAT_EN
    logic        sat;
`endif

    typedef struct {
        logic [15:0] d;
        logic        l;
        logic        s;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    int          hx[1:5];
    int          cf[0:2];
    logic [15:0] last_out = '0;

    always #5 aclk = ~aclk;

    lpffir_pipe_axis #(.DATA_W(16), .NTAPS(6), .COEF_W(16), .SHIFT(0)) dut (
        .aclk_i(aclk), .areset_i(areset),
        .rx_tvalid_i(rx_tvalid), .rx_tready_o(rx_tready),
        .rx_tdata_i(rx_tdata), .rx_tlast_i(rx_tlast),
        .tx_tvalid_o(tx_tvalid), .tx_tready_i(tx_tready),
        .tx_tdata_o(tx_tdata), .tx_tlast_o(tx_tlast),
`ifdef LPFFIR_SAT_EN
        .sat_o(sat),
`endif
        .coef_we_i(coef_we), .coef_addr_i(coef_addr), .coef_data_i(coef_data)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int j = 1; j <= 5; j++) hx[j] = 0;
        for (int k = 0; k < 3; k++) cf[k] = 1;
    endfunction

    // Direct-form reference computed on the accepted sample and bench-side history.
    function automatic void model(input logic [15:0] s, input logic l);
        int     x[0:5];
        longint acc;
        exp_t   e;
        x[0] = int'($signed(s));
        for (int j = 1; j <= 5; j++) x[j] = hx[j];
        acc = 0;
        for (int k = 0; k < 3; k++) acc += longint'(cf[k]) * longint'(x[k] + x[5-k]);
`ifdef LPFFIR_SAT_EN
        if (acc > 32767) begin
            e.d = 16'h7FFF; e.s = 1'b1;
        end else if (acc < -32768) begin
            e.d = 16'h8000; e.s = 1'b1;
        end else begin
            e.d = acc[15:0]; e.s = 1'b0;
        end
`else
        e.d = acc[15:0];
        e.s = 1'b0;
`endif
        e.l = l;
        q.push_back(e);
        if (l) begin
            for (int j = 1; j <= 5; j++) hx[j] = 0;
        end else begin
            for (int j = 5; j >= 2; j--) hx[j] = hx[j-1];
            hx[1] = x[0];
        end
    endfunction

    task automatic send(input logic [15:0] d, input logic l);
        int n = 0;
        rx_tvalid = 1'b1; rx_tdata = d; rx_tlast = l;
        @(negedge aclk);
        while (!rx_tready && n < 100) begin
            n++;
            @(negedge aclk);
        end
        if (n >= 100) chk("send_timeout", 32'(n), 0);
        else model(d, l);
        @(posedge aclk); #1;
        rx_tvalid = 1'b0;
    endtask

    task automatic coef_wr(input logic [1:0] a, input logic [15:0] d);
        coef_we = 1'b1; coef_addr = a; coef_data = d;
        @(posedge aclk); #1;
        coef_we = 1'b0;
        if (a < 3) cf[a] = int'($signed(d));
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() > 0 && n < 200) begin
            @(posedge aclk); #1;
            n++;
        end
        if (q.size() > 0) chk("drain_timeout", 32'(q.size()), 0);
        @(posedge aclk); #1;
    endtask

    always @(negedge aclk) begin
        if (!areset && tx_tvalid && tx_tready) begin
            if (q.size() == 0) begin
                chk("unexpected_out", {16'h0, tx_tdata}, 32'hDEAD_0000);
            end else begin
                mon_e = q.pop_front();
                chk("out_data", tx_tdata, mon_e.d);
                chk("out_last", tx_tlast, mon_e.l);
`ifdef LPFFIR_SAT_EN
                chk("out_sat", sat, mon_e.s);
`endif
                last_out = tx_tdata;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        areset = 1'b1; rx_tvalid = 1'b0; rx_tdata = '0; rx_tlast = 1'b0;
        tx_tready = 1'b1; coef_we = 1'b0; coef_addr = '0; coef_data = '0;
        model_reset();
        repeat (3) @(posedge aclk);
        #1;
        chk("rst_tvalid", tx_tvalid, 0);
        chk("rst_tdata", tx_tdata, 0);
        chk("rst_tlast", tx_tlast, 0);
        chk("rst_rx_tready", rx_tready, 1);
        areset = 1'b0;
        @(posedge aclk); #1;

        // impulse through unity taps, plus two-edge latency
        send(16'd1, 1'b0);
        chk("lat_valid_early", tx_tvalid, 0);
        send(16'd0, 1'b0);
        chk("lat_valid", tx_tvalid, 1);
        chk("lat_data", tx_tdata, 1);
        repeat (6) send(16'd0, 1'b0);
        drain();

        // coef[0]=2, out-of-range write ignored, constant 100
        coef_wr(2'd0, 16'd2);
        coef_wr(2'd3, 16'd99);
        repeat (8) send(16'd100, 1'b0);
        drain();
        chk("coef_steady", last_out, 800);

        // overflow at full-scale input; tlast on last beat clears history
        coef_wr(2'd0, 16'd1);
        repeat (7) send(16'h7FFF, 1'b0);
        send(16'h7FFF, 1'b1);
        drain();
`ifdef LPFFIR_SAT_EN
        chk("ovf_steady", last_out, 16'h7FFF);
`else
        chk("ovf_steady", last_out, 16'hFFFA);
`endif

        // backpressure: two accepts fill the pipe, output held stable
        tx_tready = 1'b0;
        send(16'd10, 1'b0);
        send(16'd20, 1'b0);
        rx_tvalid = 1'b1; rx_tdata = 16'd30; rx_tlast = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge aclk);
            chk("bp_rx_tready", rx_tready, 0);
            chk("bp_tvalid", tx_tvalid, 1);
            chk("bp_hold", tx_tdata, 10);
        end
        @(posedge aclk); #1;
        tx_tready = 1'b1;
        send(16'd30, 1'b0);
        send(16'd40, 1'b0);
        send(16'd50, 1'b1);
        drain();

        // packet clear: 5,5,5(last) then 7
        send(16'd5, 1'b0);
        send(16'd5, 1'b0);
        send(16'd5, 1'b1);
        send(16'd7, 1'b1);
        drain();
        chk("pkt_clear", last_out, 7);

        // async reset with both stages full
        coef_wr(2'd1, 16'd3);
        tx_tready = 1'b0;
        send(16'd9, 1'b0);
        send(16'd9, 1'b0);
        chk("pre_rst_full", tx_tvalid & !rx_tready, 1);
        #2;
        areset = 1'b1;
        #1;
        chk("rst_async_valid", tx_tvalid, 0);
        q.delete();
        model_reset();
        repeat (2) @(posedge aclk);
        #1;
        areset = 1'b0;
        tx_tready = 1'b1;
        @(posedge aclk); #1;
        send(16'd4, 1'b0);
        send(16'd4, 1'b0);
        drain();
        chk("post_rst_coef", last_out, 8);

        chk("queue_empty", 32'(q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
